keypad_scanner: RTL and testbench

Upstream input stage of the signed multiplier: drives the columns of a 4x4 matrix keypad, reads its active-low rows, debounces each press and emits one 4-bit key code per physical press. Its `key_code`/`key_valid` pair feeds the operand-entry logic of `top`, replacing the raw row vector `key_in`. Runs on the 27 MHz system clock.

---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad column scanner with per-press debounce,
//            emitting one 4-bit key code and a one-cycle valid per press.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_TICKS     = 27000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] C_DEB_DONE  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      row_meta_q;
    logic [3:0]      row_s_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      row_sel_q;
    logic [CW-1:0]   deb_cnt_q;
    logic [3:0]      col_out_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_held_q;

    logic            tick_d;
    logic            any_low_d;
    logic            row_bit_d;
    logic [1:0]      low_row_d;
    logic [1:0]      col_adv_d;
    logic [CW-1:0]   cnt_inc_d;

    function automatic logic [3:0] col_decode(input logic [1:0] idx);
        col_decode = ~(4'b0001 << idx);
    endfunction

    // Layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E, # = F.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_lookup = 4'h1;
            4'h1: key_lookup = 4'h2;
            4'h2: key_lookup = 4'h3;
            4'h3: key_lookup = 4'hA;
            4'h4: key_lookup = 4'h4;
            4'h5: key_lookup = 4'h5;
            4'h6: key_lookup = 4'h6;
            4'h7: key_lookup = 4'hB;
            4'h8: key_lookup = 4'h7;
            4'h9: key_lookup = 4'h8;
            4'hA: key_lookup = 4'h9;
            4'hB: key_lookup = 4'hC;
            4'hC: key_lookup = 4'hE;
            4'hD: key_lookup = 4'h0;
            4'hE: key_lookup = 4'hF;
            default: key_lookup = 4'hD;
        endcase
    endfunction

    always_comb begin
        tick_d    = (tick_cnt_q == C_TICK_LAST);
        any_low_d = ~(&row_s_q);
        row_bit_d = row_s_q[row_sel_q];
        col_adv_d = col_idx_q + 2'd1;
        cnt_inc_d = deb_cnt_q + CW'(1);
        // Lowest-index low row has priority when several rows are pulled down.
        if (!row_s_q[0])      low_row_d = 2'd0;
        else if (!row_s_q[1]) low_row_d = 2'd1;
        else if (!row_s_q[2]) low_row_d = 2'd2;
        else                  low_row_d = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            tick_cnt_q  <= '0;
            col_idx_q   <= 2'd0;
            row_sel_q   <= 2'd0;
            deb_cnt_q   <= '0;
            col_out_q   <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_in;
            row_s_q     <= row_meta_q;
            tick_cnt_q  <= tick_d ? '0 : tick_cnt_q + TW'(1);
            key_valid_q <= 1'b0;

            if (tick_d) begin
                case (state_q)
                    ST_SCAN: begin
                        if (any_low_d) begin
                            row_sel_q <= low_row_d;
                            deb_cnt_q <= CW'(1);
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            col_idx_q <= col_adv_d;
                            col_out_q <= col_decode(col_adv_d);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!row_bit_d) begin
                            if (cnt_inc_d == C_DEB_DONE) begin
                                key_code_q  <= key_lookup(row_sel_q, col_idx_q);
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_cnt_q   <= '0;
                                state_q     <= ST_HELD;
                            end else begin
                                deb_cnt_q <= cnt_inc_d;
                            end
                        end else begin
                            deb_cnt_q <= '0;
                            col_idx_q <= col_adv_d;
                            col_out_q <= col_decode(col_adv_d);
                            state_q   <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        // Release needs consecutive high samples; any low restarts it.
                        if (row_bit_d) begin
                            if (cnt_inc_d == C_DEB_DONE) begin
                                key_held_q <= 1'b0;
                                deb_cnt_q  <= '0;
                                col_idx_q  <= col_adv_d;
                                col_out_q  <= col_decode(col_adv_d);
                                state_q    <= ST_SCAN;
                            end else begin
                                deb_cnt_q <= cnt_inc_d;
                            end
                        end else begin
                            deb_cnt_q <= '0;
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed self-checking bench for keypad_scanner with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;       // bit r*4+c set = key (r,c) pressed
    int          checks;
    int          failures;
    int          pulse_cnt;
    logic [3:0]  last_code;

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
    end

    initial begin
        pulse_cnt = 0;
        last_code = 4'h0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            last_code = key_code;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        keys  = 16'h0020;    // '5'
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
                failures++;
                $display("FAIL reset_state cycle %0d: col=%b valid=%b held=%b code=%h, want col=1110 valid=0 held=0 code=0",
                         i, col_out, key_valid, key_held, key_code);
            end
        end
        keys  = 16'h0;
        reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_press_5;
        int p0, fall, seen_valid;
        p0 = pulse_cnt;
        seen_valid = 0;
        keys = 16'h0020;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                seen_valid++;
                checks++;
                if (key_held !== 1'b1 || key_code !== 4'h5) begin
                    failures++;
                    $display("FAIL press5_pulse: held=%b code=%h, want held=1 code=5", key_held, key_code);
                end
            end
        end
        checks++;
        if (seen_valid != 1) begin
            failures++;
            $display("FAIL press5_count: pulses=%0d, want 1", seen_valid);
        end
        checks++;
        if (col_out !== 4'b1101 || key_held !== 1'b1) begin
            failures++;
            $display("FAIL press5_frozen: col=%b held=%b, want 1101 held=1", col_out, key_held);
        end
        keys = 16'h0;
        fall = -1;
        for (int i = 1; i <= 30 && fall < 0; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) begin
                fall = i;
                checks++;
                if (col_out !== 4'b1011) begin
                    failures++;
                    $display("FAIL press5_resume: col=%b, want 1011", col_out);
                end
            end
        end
        checks++;
        if (fall < 9 || fall > 15) begin
            failures++;
            $display("FAIL press5_release: held fell after %0d cycles, want 9..15", fall);
        end
        checks++;
        if (pulse_cnt - p0 != 1 || last_code !== 4'h5) begin
            failures++;
            $display("FAIL press5_total: pulses=%0d code=%h, want 1 code=5", pulse_cnt - p0, last_code);
        end
    endtask

    task automatic test_short_press;
        int p0, found, seen_c3;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (col_out === 4'b1011) found = 1;
        end
        checks++;
        if (found == 0) begin
            failures++;
            $display("FAIL short_wait: col=%b never reached 1011", col_out);
        end
        p0 = pulse_cnt;
        keys = 16'h4000;     // '#' at r3,c2
        cycles(8);
        keys = 16'h0;
        seen_c3 = 0;
        for (int i = 0; i < 12 && seen_c3 == 0; i++) begin
            @(negedge clk);
            if (col_out === 4'b0111) seen_c3 = 1;
        end
        checks++;
        if (seen_c3 == 0) begin
            failures++;
            $display("FAIL short_resume: col=%b, want 0111 next", col_out);
        end
        cycles(20);
        checks++;
        if (pulse_cnt != p0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL short_press: pulses=%0d held=%b, want 0 held=0", pulse_cnt - p0, key_held);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulse_cnt;
        keys = 16'h8000;     // 'D' at r3,c3
        cycles(1000);
        checks++;
        if (pulse_cnt - p0 != 1 || key_held !== 1'b1 || key_code !== 4'hD) begin
            failures++;
            $display("FAIL hold_D: pulses=%0d held=%b code=%h, want 1 held=1 code=D",
                     pulse_cnt - p0, key_held, key_code);
        end
        keys = 16'h0;
        cycles(40);
        checks++;
        if (key_held !== 1'b0) begin
            failures++;
            $display("FAIL hold_D_release: held=%b, want 0", key_held);
        end
        keys = 16'h8000;
        cycles(100);
        keys = 16'h0;
        cycles(40);
        checks++;
        if (pulse_cnt - p0 != 2 || last_code !== 4'hD) begin
            failures++;
            $display("FAIL back_to_back: pulses=%0d code=%h, want 2 code=D", pulse_cnt - p0, last_code);
        end
    endtask

    task automatic test_multi_row;
        int p0;
        p0 = pulse_cnt;
        keys = 16'h0202;     // '2' (r0,c1) and '8' (r2,c1)
        cycles(100);
        checks++;
        if (pulse_cnt - p0 != 1 || last_code !== 4'h2) begin
            failures++;
            $display("FAIL multi_row: pulses=%0d code=%h, want 1 code=2", pulse_cnt - p0, last_code);
        end
        keys = 16'h0;
        cycles(40);
    endtask

    task automatic test_reset_in_held;
        int got, lat;
        keys = 16'h0100;     // '7' at r2,c0
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (key_held === 1'b1) got = 1;
        end
        checks++;
        if (got == 0) begin
            failures++;
            $display("FAIL rst_held_wait: held=%b, want 1 within 200 cycles", key_held);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (key_held !== 1'b0 || col_out !== 4'b1110 || key_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_held_state: held=%b col=%b valid=%b, want 0 1110 0", key_held, col_out, key_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (key_valid !== 1'b0 || key_code !== 4'h0) begin
                failures++;
                $display("FAIL rst_held_quiet: valid=%b code=%h, want 0 0", key_valid, key_code);
            end
        end
        reset = 1'b1;
        lat = -1;
        for (int i = 1; i <= 27 && lat < 0; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                lat = i;
                checks++;
                if (key_code !== 4'h7) begin
                    failures++;
                    $display("FAIL rst_repress_code: code=%h, want 7", key_code);
                end
            end
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL rst_repress_latency: no key_valid within 27 cycles");
        end
        keys = 16'h0;
        cycles(40);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        keys     = 16'h0;
        reset    = 1'b0;
        test_reset();
        test_press_5();
        test_short_press();
        test_back_to_back();
        test_multi_row();
        test_reset_in_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
